// File: rtl/leading_zero_normalizer.sv
// Leading-zero counter and normalizer: per-nibble counts in S1, then priority-encode and barrel shift in S2.
// Latency: a word captured into S1 at one edge reaches the registered outputs at the next edge.
// Backpressure: per-stage ready = !valid || downstream ready; a stalled stage holds its data.
// Build option: LZN_TRAILING_MODE_EN adds i_TRAILING for trailing-zero count and right shift.
module leading_zero_normalizer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int TAG_WIDTH  = 4,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_VALID,
    output logic                  o_READY,
    input  logic [DATA_WIDTH-1:0] i_WORD,
    input  logic [TAG_WIDTH-1:0]  i_TAG,
`ifdef LZN_TRAILING_MODE_EN
    input  logic                  i_TRAILING,
`endif
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic [CNT_WIDTH-1:0]  o_ZERO_COUNT,
    output logic                  o_ALL_ZEROS,
    output logic [DATA_WIDTH-1:0] o_NORMALIZED,
    output logic [TAG_WIDTH-1:0]  o_TAG
);

    localparam int NIB = DATA_WIDTH / 4;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_word;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic [2*NIB-1:0]      s1_cnt;
    logic [NIB-1:0]        s1_zero;
`ifdef LZN_TRAILING_MODE_EN
    logic                  s1_trailing;
`endif

    logic                  ready_s2;
    logic [DATA_WIDTH-1:0] word_in;
    logic [3:0]            nib;
    logic [2*NIB-1:0]      nib_cnt_in;
    logic [NIB-1:0]        nib_zero_in;

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  all_zeros;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] norm_next;

    assign ready_s2 = !o_VALID || i_READY;
    assign o_READY  = !s1_valid || ready_s2;

    // Trailing mode bit-reverses the word so both modes share one leading-zero datapath.
    always_comb begin
        word_in     = i_WORD;
        nib         = '0;
        nib_cnt_in  = '0;
        nib_zero_in = '0;
`ifdef LZN_TRAILING_MODE_EN
        if (i_TRAILING) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                word_in[i] = i_WORD[DATA_WIDTH-1-i];
            end
        end
`endif
        for (int n = 0; n < NIB; n++) begin
            nib               = word_in[4*n +: 4];
            nib_zero_in[n]    = (nib == 4'd0);
            nib_cnt_in[2*n +: 2] = nib[3] ? 2'd0 :
                                   nib[2] ? 2'd1 :
                                   nib[1] ? 2'd2 : 2'd3;
        end
    end

    // Ascending scan: the most significant non-zero nibble is the last to write cnt.
    always_comb begin
        cnt       = '0;
        all_zeros = &s1_zero;
        for (int n = 0; n < NIB; n++) begin
            if (!s1_zero[n]) begin
                cnt = CNT_WIDTH'(4 * (NIB - 1 - n)) + CNT_WIDTH'(s1_cnt[2*n +: 2]);
            end
        end
        shifted   = s1_word << cnt;
        norm_next = shifted;
`ifdef LZN_TRAILING_MODE_EN
        if (s1_trailing) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                norm_next[i] = shifted[DATA_WIDTH-1-i];
            end
        end
`endif
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            s1_valid    <= 1'b0;
            s1_word     <= '0;
            s1_tag      <= '0;
            s1_cnt      <= '0;
            s1_zero     <= '0;
`ifdef LZN_TRAILING_MODE_EN
            s1_trailing <= 1'b0;
`endif
        end else if (o_READY) begin
            s1_valid <= i_VALID;
            if (i_VALID) begin
                s1_word     <= word_in;
                s1_tag      <= i_TAG;
                s1_cnt      <= nib_cnt_in;
                s1_zero     <= nib_zero_in;
`ifdef LZN_TRAILING_MODE_EN
                s1_trailing <= i_TRAILING;
`endif
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_VALID      <= 1'b0;
            o_ZERO_COUNT <= '0;
            o_ALL_ZEROS  <= 1'b0;
            o_NORMALIZED <= '0;
            o_TAG        <= '0;
        end else if (ready_s2) begin
            o_VALID <= s1_valid;
            if (s1_valid) begin
                o_ZERO_COUNT <= cnt;
                o_ALL_ZEROS  <= all_zeros;
                o_NORMALIZED <= norm_next;
                o_TAG        <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_leading_zero_normalizer.sv
// Directed bench for leading_zero_normalizer at DATA_WIDTH=32, TAG_WIDTH=4.
module tb_leading_zero_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready_blk;
    logic [31:0] in_word;
    logic [3:0]  in_tag;
`ifdef LZN_TRAILING_MODE_EN
    logic        in_trailing;
`endif
    logic        out_valid;
    logic        ds_ready;
    logic [4:0]  zcount;
    logic        allz;
    logic [31:0] norm;
    logic [3:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    leading_zero_normalizer #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_VALID      (in_valid),
        .o_READY      (out_ready_blk),
        .i_WORD       (in_word),
        .i_TAG        (in_tag),
`ifdef LZN_TRAILING_MODE_EN
        .i_TRAILING   (in_trailing),
`endif
        .o_VALID      (out_valid),
        .i_READY      (ds_ready),
        .o_ZERO_COUNT (zcount),
        .o_ALL_ZEROS  (allz),
        .o_NORMALIZED (norm),
        .o_TAG        (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_word  = 32'hFFFF_FFFF;
        in_tag   = 4'hF;
        ds_ready = 1'b1;
        repeat (3) step();
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        if (zcount !== 5'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", zcount); end
        if (allz !== 1'b0) begin failures++; $display("FAIL reset_allz got %b exp 0", allz); end
        if (norm !== 32'h0) begin failures++; $display("FAIL reset_norm got %h exp 0", norm); end
        if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_tag got %h exp 0", out_tag); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        checks += 2;
        if (out_ready_blk !== 1'b1) begin failures++; $display("FAIL release_ready got %b exp 1", out_ready_blk); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_counts;
        logic [31:0] w  [0:5];
        logic [3:0]  t  [0:5];
        logic [4:0]  ec [0:5];
        logic [31:0] en [0:5];
        w[0] = 32'h8000_0000; t[0] = 4'h1; ec[0] = 5'd0;  en[0] = 32'h8000_0000;
        w[1] = 32'h0001_0000; t[1] = 4'h2; ec[1] = 5'd15; en[1] = 32'h8000_0000;
        w[2] = 32'h0000_0001; t[2] = 4'h3; ec[2] = 5'd31; en[2] = 32'h8000_0000;
        w[3] = 32'h1234_5678; t[3] = 4'h4; ec[3] = 5'd3;  en[3] = 32'h91A2_B3C0;
        w[4] = 32'h00F0_0000; t[4] = 4'h6; ec[4] = 5'd8;  en[4] = 32'hF000_0000;
        w[5] = 32'h0000_8001; t[5] = 4'h7; ec[5] = 5'd16; en[5] = 32'h8001_0000;
        ds_ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                in_valid = 1'b1; in_word = w[k]; in_tag = t[k];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL count_latency valid got %b exp 0", out_valid); end
            end else begin
                checks += 5;
                if (out_valid !== 1'b1) begin failures++; $display("FAIL count_%0d valid got %b exp 1", k-1, out_valid); end
                if (zcount !== ec[k-1]) begin failures++; $display("FAIL count_%0d count got %0d exp %0d", k-1, zcount, ec[k-1]); end
                if (norm !== en[k-1]) begin failures++; $display("FAIL count_%0d norm got %h exp %h", k-1, norm, en[k-1]); end
                if (allz !== 1'b0) begin failures++; $display("FAIL count_%0d allz got %b exp 0", k-1, allz); end
                if (out_tag !== t[k-1]) begin failures++; $display("FAIL count_%0d tag got %h exp %h", k-1, out_tag, t[k-1]); end
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL count_drain valid got %b exp 0", out_valid); end
    endtask

    task automatic test_zero_word;
        ds_ready = 1'b1;
        in_valid = 1'b1; in_word = 32'h0; in_tag = 4'h5;
        step();
        in_valid = 1'b0;
        step();
        checks += 5;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got %b exp 1", out_valid); end
        if (allz !== 1'b1) begin failures++; $display("FAIL zero_allz got %b exp 1", allz); end
        if (zcount !== 5'd0) begin failures++; $display("FAIL zero_count got %0d exp 0", zcount); end
        if (norm !== 32'h0) begin failures++; $display("FAIL zero_norm got %h exp 0", norm); end
        if (out_tag !== 4'h5) begin failures++; $display("FAIL zero_tag got %h exp 5", out_tag); end
        step();
    endtask

    task automatic test_back_to_back;
        logic [31:0] w  [0:3];
        logic [3:0]  t  [0:3];
        logic [4:0]  ec [0:3];
        logic [31:0] en [0:3];
        int tx;
        int rx;
        logic acc;
        w[0] = 32'h4000_0000; t[0] = 4'hA; ec[0] = 5'd1;  en[0] = 32'h8000_0000;
        w[1] = 32'h0000_0003; t[1] = 4'hB; ec[1] = 5'd30; en[1] = 32'hC000_0000;
        w[2] = 32'h0F00_0000; t[2] = 4'hC; ec[2] = 5'd4;  en[2] = 32'hF000_0000;
        w[3] = 32'h0000_8001; t[3] = 4'hD; ec[3] = 5'd16; en[3] = 32'h8001_0000;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            ds_ready = (cyc >= 5);
            if (tx < 4) begin
                in_valid = 1'b1; in_word = w[tx]; in_tag = t[tx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checks += 4;
                if (out_ready_blk !== 1'b0) begin failures++; $display("FAIL stall_ready cyc %0d got %b exp 0", cyc, out_ready_blk); end
                if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc %0d got %b exp 1", cyc, out_valid); end
                if (norm !== en[0]) begin failures++; $display("FAIL stall_norm cyc %0d got %h exp %h", cyc, norm, en[0]); end
                if (out_tag !== t[0]) begin failures++; $display("FAIL stall_tag cyc %0d got %h exp %h", cyc, out_tag, t[0]); end
            end
            if (out_valid && ds_ready) begin
                checks += 3;
                if (zcount !== ec[rx]) begin failures++; $display("FAIL bp_%0d count got %0d exp %0d", rx, zcount, ec[rx]); end
                if (norm !== en[rx]) begin failures++; $display("FAIL bp_%0d norm got %h exp %h", rx, norm, en[rx]); end
                if (out_tag !== t[rx]) begin failures++; $display("FAIL bp_%0d tag got %h exp %h", rx, out_tag, t[rx]); end
                rx++;
            end
            acc = in_valid && out_ready_blk;
            step();
            if (acc) tx++;
        end
        in_valid = 1'b0;
        checks++;
        if (rx !== 4) begin failures++; $display("FAIL bp_delivered got %0d exp 4", rx); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra valid got %b exp 0", out_valid); end
    endtask

    task automatic test_midflight_reset;
        ds_ready = 1'b1;
        in_valid = 1'b1; in_word = 32'h0000_0010; in_tag = 4'h8;
        step();
        in_word = 32'h0000_0020; in_tag = 4'h9;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset valid got %b exp 0", out_valid); end
        if (norm !== 32'h0) begin failures++; $display("FAIL mid_reset norm got %h exp 0", norm); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cyc %0d valid got %b exp 0", i, out_valid); end
        end
        in_valid = 1'b1; in_word = 32'h0000_0100; in_tag = 4'h3;
        step();
        in_valid = 1'b0;
        step();
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_after valid got %b exp 1", out_valid); end
        if (zcount !== 5'd23) begin failures++; $display("FAIL mid_after count got %0d exp 23", zcount); end
        if (out_tag !== 4'h3) begin failures++; $display("FAIL mid_after tag got %h exp 3", out_tag); end
        step();
    endtask

`ifdef LZN_TRAILING_MODE_EN
    task automatic test_trailing;
        ds_ready = 1'b1;
        in_valid = 1'b1; in_word = 32'h0000_0100; in_tag = 4'h2; in_trailing = 1'b1;
        step();
        in_word = 32'h0000_0000; in_tag = 4'h4;
        step();
        checks += 2;
        if (zcount !== 5'd8) begin failures++; $display("FAIL trail count got %0d exp 8", zcount); end
        if (norm !== 32'h0000_0001) begin failures++; $display("FAIL trail norm got %h exp 1", norm); end
        in_valid = 1'b0;
        in_trailing = 1'b0;
        step();
        checks += 3;
        if (allz !== 1'b1) begin failures++; $display("FAIL trail_zero allz got %b exp 1", allz); end
        if (zcount !== 5'd0) begin failures++; $display("FAIL trail_zero count got %0d exp 0", zcount); end
        if (norm !== 32'h0) begin failures++; $display("FAIL trail_zero norm got %h exp 0", norm); end
        step();
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        in_tag   = '0;
        ds_ready = 1'b1;
`ifdef LZN_TRAILING_MODE_EN
        in_trailing = 1'b0;
`endif
        test_reset();
        test_counts();
        test_zero_word();
        test_back_to_back();
        test_midflight_reset();
`ifdef LZN_TRAILING_MODE_EN
        test_trailing();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
